// File: rtl/r4_otfc_accum.sv
`default_nettype none
// ============================================================================
// Module      : r4_otfc_accum
// Description : Radix-4 on-the-fly quotient conversion with final sign fix.
//               Signed-digit quotient digits {-2..+2} are folded into a
//               conventional binary quotient one digit per cycle. Two words
//               are kept, Q and QM = Q-1. Each update appends two bits to one
//               of them, so no carry-propagate adder is needed. When the
//               final remainder sign arrives, Q or QM is selected as the
//               corrected quotient.
//               QUO_W must be even and at least 4.
// Ports       : clk            - clock, rising edge
//               rst            - asynchronous active-high reset
//               start_i        - begin a new operation (IDLE only)
//               flush_i        - synchronous abort to IDLE, highest priority
//               dig_vld_i      - dig_i is valid
//               dig_i[4:0]     - one-hot digit [4]=-2 [3]=-1 [2]=0 [1]=+1 [0]=+2
//               dig_rdy_o      - digit accepted this cycle (ACCUM)
//               rem_sign_vld_i - rem_neg_i is valid
//               rem_neg_i      - final remainder negative, select Q-1
//               busy_o         - not IDLE
//               out_vld_o      - quo_o / illegal_o valid (DONE)
//               out_rdy_i      - consumer accepts the result
//               quo_o          - corrected quotient, modulo 2^QUO_W
//               illegal_o      - a non-one-hot digit was seen this operation
// Revision    : 1.0 - initial release
// ============================================================================
module r4_otfc_accum #(
    parameter int QUO_W = 28,
    parameter int ITER  = QUO_W / 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic             flush_i,
    input  logic             dig_vld_i,
    input  logic [4:0]       dig_i,
    output logic             dig_rdy_o,
    input  logic             rem_sign_vld_i,
    input  logic             rem_neg_i,
    output logic             busy_o,
    output logic             out_vld_o,
    input  logic             out_rdy_i,
    output logic [QUO_W-1:0] quo_o,
    output logic             illegal_o
);

    localparam int CNT_W = $clog2(ITER + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_FIX   = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [QUO_W-1:0]   q_q, q_d;
    logic [QUO_W-1:0]   qm_q, qm_d;
    logic [QUO_W-1:0]   res_q, res_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ill_q, ill_d;

    logic               dig_legal;
    logic [4:0]         dig_eff;
    logic               dig_take;
    logic [QUO_W-1:0]   q_next;
    logic [QUO_W-1:0]   qm_next;

    // Exactly one bit set: non-zero and clearing the lowest set bit leaves zero.
    assign dig_legal = (dig_i != 5'd0) && ((dig_i & (dig_i - 5'd1)) == 5'd0);
    // Illegal digits are folded in as zero.
    assign dig_eff   = dig_legal ? dig_i : 5'b00100;
    assign dig_take  = (state_q == S_ACCUM) && dig_vld_i;

    // 4*X + k for k in 0..3 is a shift with k appended in the two new LSBs.
    // Negative digits borrow from QM, which avoids any carry propagation.
    always_comb begin
        q_next  = q_q;
        qm_next = qm_q;
        unique case (1'b1)
            dig_eff[0]: begin // +2
                q_next  = {q_q[QUO_W-3:0],  2'd2};
                qm_next = {q_q[QUO_W-3:0],  2'd1};
            end
            dig_eff[1]: begin // +1
                q_next  = {q_q[QUO_W-3:0],  2'd1};
                qm_next = {q_q[QUO_W-3:0],  2'd0};
            end
            dig_eff[3]: begin // -1
                q_next  = {qm_q[QUO_W-3:0], 2'd3};
                qm_next = {qm_q[QUO_W-3:0], 2'd2};
            end
            dig_eff[4]: begin // -2
                q_next  = {qm_q[QUO_W-3:0], 2'd2};
                qm_next = {qm_q[QUO_W-3:0], 2'd1};
            end
            default: begin // 0
                q_next  = {q_q[QUO_W-3:0],  2'd0};
                qm_next = {qm_q[QUO_W-3:0], 2'd3};
            end
        endcase
    end

    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        qm_d    = qm_q;
        res_d   = res_q;
        cnt_d   = cnt_q;
        ill_d   = ill_q;

        if (flush_i) begin
            // Result register is left alone so quo_o keeps its last value.
            state_d = S_IDLE;
            cnt_d   = '0;
            ill_d   = 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        state_d = S_ACCUM;
                        q_d     = '0;
                        qm_d    = '1;
                        cnt_d   = '0;
                        ill_d   = 1'b0;
                    end
                end
                S_ACCUM: begin
                    if (dig_take) begin
                        q_d   = q_next;
                        qm_d  = qm_next;
                        cnt_d = cnt_q + 1'b1;
                        ill_d = ill_q | ~dig_legal;
                        if (cnt_q == CNT_W'(ITER - 1)) begin
                            state_d = S_FIX;
                        end
                    end
                end
                S_FIX: begin
                    if (rem_sign_vld_i) begin
                        res_d   = rem_neg_i ? qm_q : q_q;
                        state_d = S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_rdy_i) begin
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            q_q     <= '0;
            qm_q    <= '1;
            res_q   <= '0;
            cnt_q   <= '0;
            ill_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            qm_q    <= qm_d;
            res_q   <= res_d;
            cnt_q   <= cnt_d;
            ill_q   <= ill_d;
        end
    end

    assign dig_rdy_o = (state_q == S_ACCUM);
    assign busy_o    = (state_q != S_IDLE);
    assign out_vld_o = (state_q == S_DONE);
    assign quo_o     = res_q;
    assign illegal_o = ill_q;

endmodule
`default_nettype wire

// File: tb/tb_r4_otfc_accum.sv
`default_nettype none
// ============================================================================
// Module      : tb_r4_otfc_accum
// Description : Self-checking bench for r4_otfc_accum with QUO_W=8, ITER=4.
//               Table vectors and random operations push expected results to
//               a scoreboard queue, and the results are popped when out_vld_o
//               rises. Hand-written sequences cover hold, back-to-back,
//               async reset and flush.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_r4_otfc_accum;

    localparam int W = 8;

    localparam logic [4:0] DM2 = 5'b10000;
    localparam logic [4:0] DM1 = 5'b01000;
    localparam logic [4:0] D0  = 5'b00100;
    localparam logic [4:0] DP1 = 5'b00010;
    localparam logic [4:0] DP2 = 5'b00001;

    logic         clk = 1'b0;
    logic         rst;
    logic         start_i, flush_i, dig_vld_i, rem_sign_vld_i, rem_neg_i, out_rdy_i;
    logic [4:0]   dig_i;
    logic         dig_rdy_o, busy_o, out_vld_o, illegal_o;
    logic [W-1:0] quo_o;

    r4_otfc_accum #(.QUO_W(W)) dut (
        .clk            (clk),
        .rst            (rst),
        .start_i        (start_i),
        .flush_i        (flush_i),
        .dig_vld_i      (dig_vld_i),
        .dig_i          (dig_i),
        .dig_rdy_o      (dig_rdy_o),
        .rem_sign_vld_i (rem_sign_vld_i),
        .rem_neg_i      (rem_neg_i),
        .busy_o         (busy_o),
        .out_vld_o      (out_vld_o),
        .out_rdy_i      (out_rdy_i),
        .quo_o          (quo_o),
        .illegal_o      (illegal_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] quo;
        logic         ill;
        int           lat;
    } exp_t;

    typedef struct {
        logic [3:0][4:0] dig;   // dig[3] is applied first
        int              gap;   // idle cycles between digits 2 and 3
        logic            neg;
        exp_t            e;
    } vec_t;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    vec_t tbl[4];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, expv);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Reference value of a digit code; anything not one-hot counts as zero.
    function automatic int dval(input logic [4:0] d);
        case (d)
            DM2:     return -2;
            DM1:     return -1;
            DP1:     return 1;
            DP2:     return 2;
            default: return 0;
        endcase
    endfunction

    task automatic run_op(input logic [3:0][4:0] d, input int gap, input logic neg,
                          input exp_t e, input string nm);
        int   lat;
        exp_t got;
        sb.push_back(e);
        start_i        = 1'b1;
        rem_sign_vld_i = 1'b1;
        rem_neg_i      = neg;
        tick;
        start_i = 1'b0;
        lat     = 1;
        for (int i = 0; i < 4; i++) begin
            if (i == 2) begin
                repeat (gap) begin
                    dig_vld_i = 1'b0;
                    tick;
                    lat++;
                end
            end
            dig_vld_i = 1'b1;
            dig_i     = d[3-i];
            tick;
            lat++;
        end
        dig_vld_i = 1'b0;
        dig_i     = '0;
        while (!out_vld_o && lat < 40) begin
            tick;
            lat++;
        end
        chk({nm, " out_vld"}, 32'(out_vld_o), 32'd1);
        if (sb.size() > 0) begin
            got = sb.pop_front();
            chk({nm, " quo"},     32'(quo_o),     32'(got.quo));
            chk({nm, " illegal"}, 32'(illegal_o), 32'(got.ill));
            chk({nm, " latency"}, 32'(lat),       32'(got.lat));
        end
        out_rdy_i = 1'b1;
        tick;
        out_rdy_i = 1'b0;
        chk({nm, " idle after handshake"}, 32'(busy_o), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0][4:0] rd;
        int              acc;
        int              sel;
        logic            rill;
        logic            rneg;
        int              rgap;
        exp_t            re;
        int              seen;

        tbl[0] = '{dig: {DP2, DP1, D0, DM1},       gap: 0, neg: 1'b0, e: '{quo: 8'h8F, ill: 1'b0, lat: 6}};
        tbl[1] = '{dig: {DM2, DM2, DM2, DM2},      gap: 0, neg: 1'b1, e: '{quo: 8'h55, ill: 1'b0, lat: 6}};
        tbl[2] = '{dig: {DP1, 5'b00011, DP1, DP1}, gap: 2, neg: 1'b0, e: '{quo: 8'h45, ill: 1'b1, lat: 8}};
        tbl[3] = '{dig: {DP2, 5'b00000, DP2, DP2}, gap: 0, neg: 1'b1, e: '{quo: 8'h89, ill: 1'b1, lat: 6}};

        rst = 1'b1;
        start_i = 1'b0; flush_i = 1'b0; dig_vld_i = 1'b0; dig_i = '0;
        rem_sign_vld_i = 1'b0; rem_neg_i = 1'b0; out_rdy_i = 1'b0;

        // Reset is asynchronous, so the outputs settle before any clock edge.
        #1;
        chk("reset quo",      32'(quo_o),     32'd0);
        chk("reset illegal",  32'(illegal_o), 32'd0);
        chk("reset busy",     32'(busy_o),    32'd0);
        chk("reset dig_rdy",  32'(dig_rdy_o), 32'd0);
        chk("reset out_vld",  32'(out_vld_o), 32'd0);
        repeat (2) tick;
        rst = 1'b0;
        tick;

        for (int t = 0; t < 4; t++) begin
            run_op(tbl[t].dig, tbl[t].gap, tbl[t].neg, tbl[t].e, $sformatf("vec%0d", t));
        end

        // Random operations checked against an integer model of the digit sum.
        for (int r = 0; r < 6; r++) begin
            acc  = 0;
            rill = 1'b0;
            for (int i = 0; i < 4; i++) begin
                sel = $urandom_range(0, 5);
                case (sel)
                    0:       rd[3-i] = DM2;
                    1:       rd[3-i] = DM1;
                    2:       rd[3-i] = D0;
                    3:       rd[3-i] = DP1;
                    4:       rd[3-i] = DP2;
                    default: rd[3-i] = ($urandom_range(0, 1) == 0) ? 5'b00000 : 5'b10001;
                endcase
                if (sel == 5) rill = 1'b1;
                acc = acc * 4 + dval(rd[3-i]);
            end
            rneg   = 1'($urandom_range(0, 1));
            rgap   = $urandom_range(0, 2);
            re.quo = W'((acc - int'(rneg)) & 255);
            re.ill = rill;
            re.lat = 6 + rgap;
            run_op(rd, rgap, rneg, re, $sformatf("rnd%0d", r));
        end

        // Hold in DONE with out_rdy_i low; a start pulse there is ignored.
        start_i = 1'b1; rem_sign_vld_i = 1'b1; rem_neg_i = 1'b0;
        tick;
        start_i = 1'b0; dig_vld_i = 1'b1; dig_i = DP1;
        repeat (4) tick;
        dig_vld_i = 1'b0;
        tick;
        chk("hold initial out_vld", 32'(out_vld_o), 32'd1);
        chk("hold initial quo",     32'(quo_o),     32'h55);
        for (int i = 0; i < 5; i++) begin
            start_i = (i == 2);
            tick;
            chk($sformatf("hold%0d out_vld", i), 32'(out_vld_o), 32'd1);
            chk($sformatf("hold%0d quo", i),     32'(quo_o),     32'h55);
        end
        start_i   = 1'b0;
        out_rdy_i = 1'b1;
        tick;
        out_rdy_i = 1'b0;
        chk("release busy",    32'(busy_o),    32'd0);
        chk("release out_vld", 32'(out_vld_o), 32'd0);
        chk("release quo held", 32'(quo_o),    32'h55);
        start_i = 1'b1;
        tick;
        start_i = 1'b0;
        chk("back-to-back busy",    32'(busy_o),    32'd1);
        chk("back-to-back dig_rdy", 32'(dig_rdy_o), 32'd1);
        flush_i = 1'b1;
        tick;
        flush_i = 1'b0;

        // Async reset after the second digit of an operation.
        start_i = 1'b1;
        tick;
        start_i = 1'b0; dig_vld_i = 1'b1; dig_i = 5'b00011;
        tick;
        dig_i = DP2;
        tick;
        dig_vld_i = 1'b0;
        chk("pre-reset illegal", 32'(illegal_o), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("mid reset quo",     32'(quo_o),     32'd0);
        chk("mid reset illegal", 32'(illegal_o), 32'd0);
        chk("mid reset busy",    32'(busy_o),    32'd0);
        chk("mid reset dig_rdy", 32'(dig_rdy_o), 32'd0);
        chk("mid reset out_vld", 32'(out_vld_o), 32'd0);
        rst = 1'b0;
        tick;
        run_op(tbl[0].dig, tbl[0].gap, tbl[0].neg, tbl[0].e, "post-reset");

        // Flush after the third digit; the following operation must start fresh.
        start_i = 1'b1;
        tick;
        start_i = 1'b0; dig_vld_i = 1'b1; dig_i = 5'b11000;
        repeat (3) tick;
        dig_vld_i = 1'b0;
        flush_i   = 1'b1;
        tick;
        flush_i = 1'b0;
        chk("flush busy",     32'(busy_o),    32'd0);
        chk("flush out_vld",  32'(out_vld_o), 32'd0);
        chk("flush quo held", 32'(quo_o),     32'h8F);
        chk("flush illegal",  32'(illegal_o), 32'd0);
        seen = 0;
        repeat (4) begin
            tick;
            if (out_vld_o) seen = 1;
        end
        chk("flush no out_vld", 32'(seen), 32'd0);
        run_op(tbl[1].dig, tbl[1].gap, tbl[1].neg, tbl[1].e, "post-flush");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
